// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 8-bit CPU: owns PC/IR, fetches over rd/ack, strobes RF writeback, takes branches.
// Latency 3 + fetch cycles per instruction; fetch waits on pmem_ack_i and faults after FETCH_TIMEOUT cycles.
module cpu_sequencer #(
  parameter logic [6:0] START_ADDR    = 7'd0,
  parameter logic [7:0] FETCH_TIMEOUT = 8'd16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        stop_i,
  output logic [6:0]  pmem_addr_o,
  output logic        pmem_rd_o,
  input  logic        pmem_ack_i,
  input  logic [12:0] pmem_data_i,
  output logic [12:0] instr_o,
  input  logic        branch_en_i,
  input  logic [6:0]  branch_addr_i,
  input  logic        wr_en_i,
  input  logic        zero_flag_i,
  output logic        rf_wr_strobe_o,
  output logic [6:0]  pc_o,
  output logic        busy_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [15:0] retired_o
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

  state_t      state;
  logic [6:0]  pc;
  logic [12:0] ir;
  logic        z_q;
  logic [7:0]  cnt;
  logic        fault;
  logic [15:0] retired;

  logic is_alu, is_ldi, is_halt, taken;

  assign is_alu  = ~ir[12];
  assign is_ldi  = (ir[12:9] == 4'b1010);
  assign is_halt = (ir[12:11] == 2'b11);
  // Conditional branches (IR[9]=1) consult the zero flag latched in the last ALU EXECUTE.
  assign taken   = branch_en_i && (!ir[9] || z_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pc      <= START_ADDR;
      ir      <= 13'h0;
      z_q     <= 1'b0;
      cnt     <= 8'd0;
      fault   <= 1'b0;
      retired <= 16'd0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (run_i) begin
            pc    <= START_ADDR;
            fault <= 1'b0;
            cnt   <= 8'd0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (pmem_ack_i) begin
            ir    <= pmem_data_i;
            cnt   <= 8'd0;
            state <= DECODE;
          end else if (cnt == FETCH_TIMEOUT - 8'd1) begin
            fault <= 1'b1;
            cnt   <= 8'd0;
            state <= HALT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DECODE: state <= is_halt ? HALT : EXECUTE;
        EXECUTE: begin
          if (is_alu) z_q <= zero_flag_i;
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          retired <= retired + 16'd1;
          pc      <= taken ? branch_addr_i : pc + 7'd1;
          state   <= stop_i ? IDLE : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_addr_o    = pc;
  assign pc_o           = pc;
  assign instr_o        = ir;
  assign fault_o        = fault;
  assign retired_o      = retired;
  assign pmem_rd_o      = (state == FETCH);
  assign halted_o       = (state == HALT);
  assign busy_o         = (state == FETCH) || (state == DECODE) ||
                          (state == EXECUTE) || (state == WRITEBACK);
  assign rf_wr_strobe_o = (state == WRITEBACK) && wr_en_i && (is_alu || is_ldi);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: behavioural program memory, decoder/ALU stand-ins, and a
// retirement scoreboard (expected PC / count / write strobe queued per instruction).
module tb_cpu_sequencer;

  logic        clk, rst, run, stop;
  logic [6:0]  pmem_addr;
  logic        pmem_rd, pmem_ack;
  logic [12:0] pmem_data, instr;
  logic        branch_en, wr_en, zero_flag;
  logic [6:0]  branch_addr;
  logic        rf_wr_strobe, busy, halted, fault;
  logic [6:0]  pc;
  logic [15:0] retired;

  cpu_sequencer #(.START_ADDR(7'd0), .FETCH_TIMEOUT(8'd16)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .stop_i(stop),
    .pmem_addr_o(pmem_addr), .pmem_rd_o(pmem_rd), .pmem_ack_i(pmem_ack),
    .pmem_data_i(pmem_data), .instr_o(instr), .branch_en_i(branch_en),
    .branch_addr_i(branch_addr), .wr_en_i(wr_en), .zero_flag_i(zero_flag),
    .rf_wr_strobe_o(rf_wr_strobe), .pc_o(pc), .busy_o(busy), .halted_o(halted),
    .fault_o(fault), .retired_o(retired)
  );

  // Decoder stand-in; the ALU zero result is taken from IR[8] of ALU instructions.
  assign branch_en   = (instr[12:10] == 3'b100);
  assign branch_addr = instr[6:0];
  assign wr_en       = !instr[12] || (instr[12:9] == 4'b1010);
  assign zero_flag   = instr[8] & !instr[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  pc;
    logic [15:0] ret;
    logic        strobe;
  } exp_t;
  exp_t exp_q[$];

  logic [12:0] mem [128];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fetch_cycles = 1;
  int wcnt = 0;
  logic        prev_rd = 1'b0, prev_strobe = 1'b0;
  logic [6:0]  prev_addr = 7'd0;
  logic [15:0] prev_ret = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] p, input logic [15:0] r, input logic s);
    exp_t e;
    e.pc = p; e.ret = r; e.strobe = s;
    exp_q.push_back(e);
  endtask

  // One clock: sample #1 after the edge, run the scoreboard monitor, then drive memory response.
  task automatic tick();
    logic rst_edge;
    exp_t e;
    rst_edge = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_edge) begin
      if (pmem_rd && prev_rd) chk("addr_stable", pmem_addr, prev_addr);
      if (prev_strobe) chk("strobe_then_retire", retired != prev_ret, 1);
      if (retired != prev_ret) begin
        vectors++;
        assert (exp_q.size() > 0) else begin
          miscompares++;
          $error("FAIL sb_underflow observed retire=%0h expected none", retired);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_pc", pc, e.pc);
          chk("sb_retired", retired, e.ret);
          chk("sb_strobe", prev_strobe, e.strobe);
        end
      end
    end
    prev_rd = pmem_rd; prev_addr = pmem_addr; prev_ret = retired; prev_strobe = rf_wr_strobe;
    if (pmem_rd) begin
      if (fetch_cycles != 0 && wcnt == fetch_cycles - 1) begin
        pmem_ack = 1'b1; pmem_data = mem[pmem_addr]; wcnt = 0;
      end else begin
        pmem_ack = 1'b0; wcnt++;
      end
    end else begin
      pmem_ack = 1'b0; wcnt = 0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget && busy; n++) tick();
    chk(tag, busy, 0);
  endtask

  task automatic wait_retire(input string tag, input int budget, output int at);
    logic [15:0] r0;
    r0 = retired;
    for (int n = 0; n < budget && retired == r0; n++) tick();
    chk(tag, retired != r0, 1);
    at = cyc;
  endtask

  task automatic start();
    run = 1'b1; tick(); run = 1'b0;
  endtask

  logic [7:0] rd_pat, st_pat;
  int t0, t1;

  initial begin
    rst = 1'b1; run = 1'b0; stop = 1'b0; pmem_ack = 1'b0; pmem_data = 13'h0;
    for (int a = 0; a < 128; a++) mem[a] = 13'h1800;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", pc, 7'd0);       chk("rst_instr", instr, 13'h0);
    chk("rst_rd", pmem_rd, 0);     chk("rst_strobe", rf_wr_strobe, 0);
    chk("rst_busy", busy, 0);      chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);    chk("rst_retired", retired, 16'd0);

    // Same-cycle ack: ALU then NOP, then HALT at 2.
    mem[0] = 13'h0123; mem[1] = 13'h1600; mem[2] = 13'h1800;
    push(7'd1, 16'd1, 1'b1); push(7'd2, 16'd2, 1'b0);
    rd_pat = 8'b0001_0001; st_pat = 8'b0000_1000;
    start();
    for (int i = 0; i < 8; i++) begin
      chk("t1_rd", pmem_rd, rd_pat[i]);
      chk("t1_strobe", rf_wr_strobe, st_pat[i]);
      chk("t1_busy", busy, 1);
      chk("t1_pc", pc, (i < 4) ? 7'd0 : 7'd1);
      tick();
    end
    wait_done("t1_done", 20);
    chk("t1_halted", halted, 1); chk("t1_pc_halt", pc, 7'd2); chk("t1_retired", retired, 16'd2);

    // Three-cycle fetch: six cycles per instruction.
    fetch_cycles = 3;
    push(7'd1, 16'd3, 1'b1); push(7'd2, 16'd4, 1'b0);
    start();
    t0 = cyc;
    wait_retire("t2_ret0", 30, t1); chk("t2_gap0", t1 - t0, 6);
    t0 = t1;
    wait_retire("t2_ret1", 30, t1); chk("t2_gap1", t1 - t0, 6);
    wait_done("t2_done", 30);
    chk("t2_halted", halted, 1); chk("t2_pc", pc, 7'd2);

    // Branches and PC wrap.
    fetch_cycles = 1;
    mem[0] = 13'h107F; mem[7'h7F] = 13'h1600; mem[1] = 13'h122A; mem[7'h2A] = 13'h0045;
    mem[7'h2B] = 13'h1250; mem[7'h2C] = 13'h1060; mem[7'h60] = 13'h1405; mem[7'h61] = 13'h1800;
    push(7'h7F, 16'd5, 1'b0);  push(7'h00, 16'd6, 1'b0);  push(7'h01, 16'd7, 1'b1);
    push(7'h2A, 16'd8, 1'b0);  push(7'h2B, 16'd9, 1'b1);  push(7'h2C, 16'd10, 1'b0);
    push(7'h60, 16'd11, 1'b0); push(7'h61, 16'd12, 1'b1);
    start();
    wait_retire("t3_first", 20, t1);
    mem[0] = 13'h0100;
    wait_done("t3_done", 100);
    chk("t3_halted", halted, 1); chk("t3_pc", pc, 7'h61); chk("t3_retired", retired, 16'd12);

    // Fetch timeout.
    fetch_cycles = 0;
    start();
    chk("t4_rd", pmem_rd, 1); chk("t4_fault_clr", fault, 0);
    repeat (15) tick();
    chk("t4_halted_early", halted, 0); chk("t4_busy_early", busy, 1);
    tick();
    chk("t4_halted", halted, 1); chk("t4_fault", fault, 1); chk("t4_busy", busy, 0);
    chk("t4_instr", instr, 13'h1800); chk("t4_pc", pc, 7'd0);

    // Restart clears fault; HALT at PC=5.
    fetch_cycles = 1;
    for (int a = 0; a < 5; a++) mem[a] = 13'h1600;
    mem[5] = 13'h1800;
    for (int k = 1; k <= 5; k++) push(7'(k), 16'(12 + k), 1'b0);
    start();
    chk("t5_fault_clr", fault, 0); chk("t5_rd", pmem_rd, 1); chk("t5_addr", pmem_addr, 7'd0);
    wait_done("t5_done", 60);
    chk("t5_halted", halted, 1); chk("t5_pc", pc, 7'd5); chk("t5_retired", retired, 16'd17);

    // stop_i held from restart: ignored until WRITEBACK, then IDLE.
    stop = 1'b1;
    push(7'd1, 16'd18, 1'b0);
    start();
    wait_done("t5_stop_done", 20);
    chk("t5_stop_halted", halted, 0); chk("t5_stop_pc", pc, 7'd1); chk("t5_stop_ret", retired, 16'd18);
    repeat (3) tick();
    chk("t5_idle_rd", pmem_rd, 0); chk("t5_idle_busy", busy, 0);
    stop = 1'b0;

    // Reset during FETCH.
    fetch_cycles = 3;
    start(); tick();
    chk("t6_rd", pmem_rd, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6f_pc", pc, 7'd0); chk("t6f_instr", instr, 13'h0); chk("t6f_rd", pmem_rd, 0);
    chk("t6f_busy", busy, 0); chk("t6f_retired", retired, 16'd0); chk("t6f_halted", halted, 0);

    // Reset during WRITEBACK of an ALU op that set the zero flag.
    fetch_cycles = 1;
    mem[0] = 13'h0100;
    start(); tick(); tick(); tick();
    chk("t6w_strobe_wb", rf_wr_strobe, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6w_strobe", rf_wr_strobe, 0); chk("t6w_retired", retired, 16'd0);
    chk("t6w_pc", pc, 7'd0); chk("t6w_instr", instr, 13'h0); chk("t6w_busy", busy, 0);
    chk("t6w_fault", fault, 0);

    // Zero flag cleared by reset: conditional branch falls through.
    mem[0] = 13'h1233; mem[1] = 13'h1800; mem[7'h33] = 13'h1800;
    push(7'd1, 16'd1, 1'b0);
    start();
    wait_done("t6z_done", 20);
    chk("t6z_pc", pc, 7'd1); chk("t6z_halted", halted, 1); chk("t6z_retired", retired, 16'd1);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
